alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv.sv | 181 ++++++++++++++++++
 tb/tb_alu_muldiv.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: single-cycle ALU with optional iterative mul/divu/remu.
// Ports: clk, rst (sync, active-high); in_valid/in_ready request handshake;
//   src_a, src_b, ctrl operands and op select; out_valid/out_ready result
//   handshake; result, z registered result and zero flag.
// Define ALU_MULDIV_EN to build the multi-cycle multiply/divide unit;
//   without it ctrl 1010-1100 decode as illegal ops (result 0, one cycle).
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [3:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
`ifdef ALU_MULDIV_EN
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011;
    localparam logic [3:0] OP_REMU = 4'b1100;
`endif

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             accept;
    logic             is_long;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] alu_res;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign shamt     = src_b[SW-1:0];

`ifdef ALU_MULDIV_EN
    assign is_long = (ctrl == OP_MUL) || (ctrl == OP_DIVU)
                  || (ctrl == OP_REMU);
`else
    assign is_long = 1'b0;
`endif

    always_comb begin
        alu_res = '0;
        case (ctrl)
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a + ~src_b + WIDTH'(1);
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                                $signed(src_a) < $signed(src_b)};
            OP_SLL:  alu_res = src_a << shamt;
            OP_SRL:  alu_res = src_a >> shamt;
            OP_SRA:  alu_res = $signed(src_a) >>> shamt;
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic [3:0]       op;
    logic [SW-1:0]    cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a_nx;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] fin;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             last;

    assign last = (cnt == SW'(WIDTH - 1));

    // mul: acc += multiplicand (op_a) when multiplier lsb (op_b[0]) is set.
    // div: op_a holds dividend bits shifting out and quotient bits
    // shifting in; acc is the partial remainder. A zero divisor always
    // "fits", giving quotient all ones and remainder equal to the dividend.
    always_comb begin
        rem_sh = {acc, op_a[WIDTH-1]};
        diff   = rem_sh - {1'b0, op_b};
        a_nx   = {op_a[WIDTH-2:0], 1'b0};
        acc_nx = acc;
        fin    = '0;
        if (op == OP_MUL) begin
            if (op_b[0]) begin
                acc_nx = acc + op_a;
            end
            fin = acc_nx;
        end else begin
            acc_nx = rem_sh[WIDTH-1:0];
            if (!diff[WIDTH]) begin
                acc_nx = diff[WIDTH-1:0];
                a_nx   = {op_a[WIDTH-2:0], 1'b1};
            end
            fin = (op == OP_DIVU) ? a_nx : acc_nx;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = IDLE;
`ifdef ALU_MULDIV_EN
            BUSY: if (last) state_nx = DONE;
`else
            BUSY: state_nx = IDLE;
`endif
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (accept) begin
            state_nx = is_long ? BUSY : DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            z      <= 1'b0;
`ifdef ALU_MULDIV_EN
            cnt    <= '0;
`endif
        end else if (accept && !is_long) begin
            result <= alu_res;
            z      <= (alu_res == '0);
`ifdef ALU_MULDIV_EN
        end else if (accept) begin
            op   <= ctrl;
            op_a <= src_a;
            op_b <= src_b;
            acc  <= '0;
            cnt  <= '0;
        end else if (state == BUSY) begin
            op_a <= a_nx;
            acc  <= acc_nx;
            cnt  <= cnt + SW'(1);
            if (op == OP_MUL) begin
                op_b <= op_b >> 1;
            end
            if (last) begin
                result <= fin;
                z      <= (fin == '0);
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed table, hand sequences and random ops
// against an arithmetic reference model of alu_muldiv.
module tb_alu_muldiv;
`ifdef ALU_MULDIV_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [3:0]  ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        z;

    int n_vec = 0;
    int n_err = 0;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .src_a    (src_a),
        .src_b    (src_b),
        .ctrl     (ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .z        (z)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] c,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        int unsigned sh;
        logic [63:0] p;
        sh = b[4:0];
        p  = 64'(a) * 64'(b);
        case (c)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return (a < b) ? 32'd1 : 32'd0;
            4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  return a << sh;
            4'd8:  return a >> sh;
            4'd9:  return 32'($signed(a) >>> sh);
            4'd10: return EN ? p[31:0] : 32'd0;
            4'd11: return !EN ? 32'd0 : (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd12: return !EN ? 32'd0 : (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [3:0] c);
        return (EN && c >= 4'd10 && c <= 4'd12) ? 33 : 1;
    endfunction

    task automatic do_op(input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input int stall,
                         output logic [31:0] r, output logic zz,
                         output int lat, output int bsy);
        ctrl      = c;
        src_a     = a;
        src_b     = b;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        #1;
        chk("in_ready_pre", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        ctrl     = 4'($urandom);
        src_a    = $urandom;
        src_b    = $urandom;
        lat = 1;
        bsy = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) bsy++;
            @(posedge clk); #1;
            lat++;
        end
        r  = result;
        zz = z;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("hold_res", result, r);
            chk("hold_z", 32'(z), 32'(zz));
            chk("hold_ov", 32'(out_valid), 32'd1);
            chk("hold_rdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("ov_after", 32'(out_valid), 32'd0);
    endtask

    task automatic run_vec(input string nm, input logic [3:0] c,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int stall);
        logic [31:0] r;
        logic        zz;
        int          lat;
        int          bsy;
        do_op(c, a, b, stall, r, zz, lat, bsy);
        chk({nm, "_res"}, r, exp);
        chk({nm, "_z"}, 32'(zz), 32'(exp == 0));
        chk({nm, "_lat"}, 32'(lat), 32'(exp_lat(c)));
        chk({nm, "_busy"}, 32'(bsy), 32'(exp_lat(c) - 1));
    endtask

    task automatic add_vec(input logic [3:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] r);
        vec_t v;
        v.c = c;
        v.a = a;
        v.b = b;
        v.r = r;
        tbl.push_back(v);
    endtask

    initial begin
        int hi;
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;

        add_vec(4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0);
        add_vec(4'b0001, 32'd5, 32'd7, 32'hFFFF_FFFE);
        add_vec(4'b0010, 32'hF0F0, 32'h0FF0, 32'h00F0);
        add_vec(4'b0011, 32'hF000_0000, 32'h1, 32'hF000_0001);
        add_vec(4'b0100, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
        add_vec(4'b0101, 32'hFFFF_FFFF, 32'h1, 32'h0);
        add_vec(4'b0110, 32'hFFFF_FFFF, 32'h1, 32'h1);
        add_vec(4'b0111, 32'h1, 32'h23, 32'h8);
        add_vec(4'b1000, 32'h8000_0000, 32'h4, 32'h0800_0000);
        add_vec(4'b1001, 32'h8000_0000, 32'h4, 32'hF800_0000);
        add_vec(4'b1111, 32'h1234, 32'h5678, 32'h0);
        add_vec(4'b1101, 32'hFFFF, 32'h1, 32'h0);
        add_vec(4'b1010, 32'h1234, 32'h10, EN ? 32'h12340 : 32'h0);
        add_vec(4'b1011, 32'd100, 32'd7, EN ? 32'd14 : 32'h0);
        add_vec(4'b1100, 32'd100, 32'd7, EN ? 32'd2 : 32'h0);
        add_vec(4'b1011, 32'd5, 32'd0, EN ? 32'hFFFF_FFFF : 32'h0);
        add_vec(4'b1100, 32'd5, 32'd0, EN ? 32'd5 : 32'h0);

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ctrl      = '0;
        src_a     = '0;
        src_b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_res", result, 32'd0);
        chk("rst_z", 32'(z), 32'd0);
        rst = 1'b0;
        chk("rst_rdy", 32'(in_ready), 32'd1);

        foreach (tbl[i]) begin
            run_vec($sformatf("tbl%0d", i), tbl[i].c, tbl[i].a,
                    tbl[i].b, tbl[i].r, 0);
        end

        // xor held in DONE for 5 cycles, then back-to-back accept
        begin
            logic [31:0] r;
            logic        zz;
            int          lat;
            int          bsy;
            ctrl      = 4'b0100;
            src_a     = 32'h0F0F_0000;
            src_b     = 32'h00FF_00FF;
            in_valid  = 1'b1;
            out_ready = 1'b0;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("x_ov", 32'(out_valid), 32'd1);
            chk("x_res", result, 32'h0FF0_00FF);
            r  = result;
            zz = z;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                chk("x_hold_res", result, r);
                chk("x_hold_z", 32'(z), 32'(zz));
                chk("x_hold_ov", 32'(out_valid), 32'd1);
                chk("x_hold_rdy", 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
            in_valid  = 1'b1;
            ctrl      = 4'b0000;
            src_a     = 32'd3;
            src_b     = 32'd4;
            #1;
            chk("b2b_rdy", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("b2b_ov", 32'(out_valid), 32'd1);
            chk("b2b_res", result, 32'd7);
            @(posedge clk); #1;
            chk("b2b_idle", 32'(out_valid), 32'd0);
            lat = 0;
            bsy = 0;
        end

        // reset on the 10th BUSY cycle of divu
        ctrl      = 4'b1011;
        src_a     = 32'd1000;
        src_b     = 32'd3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("c10_rdy", 32'(in_ready), EN ? 32'd0 : 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ov", 32'(out_valid), 32'd0);
        chk("abort_res", result, 32'd0);
        chk("abort_z", 32'(z), 32'd0);
        chk("abort_rdy", 32'(in_ready), 32'd1);
        hi = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) hi++;
        end
        chk("abort_quiet", 32'(hi), 32'd0);
        run_vec("post_rst_add", 4'b0000, 32'd3, 32'd4, 32'd7, 0);

        // reset wins over an accept on the same edge
        ctrl     = 4'b0000;
        src_a    = 32'd1;
        src_b    = 32'd1;
        in_valid = 1'b1;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("prio_ov", 32'(out_valid), 32'd0);
        chk("prio_res", result, 32'd0);
        @(posedge clk); #1;
        chk("prio_ov2", 32'(out_valid), 32'd0);

        for (int i = 0; i < 400; i++) begin
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9))
                                            : $urandom;
            run_vec($sformatf("rnd%0d_c%0d", i, c), c, a, b,
                    model(c, a, b), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
